// File: rtl/sfp_frame_handler.sv
// Bridge between the MPS core's parallel SFP frame bus and the Aurora 64B/66B user AXI-Stream.
// TX serialises one latched frame (lowest beat first); RX reassembles beats and flags good or bad frames.
//
// state    | meaning
// TX_IDLE  | waiting for a start-flag rising edge with the channel up
// TX_SEND  | presenting beats on m_axis, advancing on each handshake
// RX_RUN   | assembling beats into the frame buffer
// RX_DROP  | discarding the tail of an over-long frame until its tlast
module sfp_frame_handler #(
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int C_NUMBER_OF_FRAME  = 2,
    parameter int C_DATA_FRAME_BIT   = C_AXIS_TDATA_WIDTH * C_NUMBER_OF_FRAME,
    parameter int C_RX_TIMEOUT       = 1000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_channel_up,
    input  logic                          i_tx_start_flag,
    input  logic [C_DATA_FRAME_BIT-1:0]   i_tx_data,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic [C_DATA_FRAME_BIT-1:0]   o_rx_data,
    output logic                          o_rx_end_flag,
    output logic                          o_tx_busy,
    output logic                          o_rx_err,
    output logic [15:0]                   o_rx_frame_cnt
);
    localparam int W     = C_AXIS_TDATA_WIDTH;
    localparam int N     = C_NUMBER_OF_FRAME;
    localparam int IDX_W = (N > 2) ? $clog2(N) : 1;
    localparam int TMR_W = $clog2(C_RX_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(C_RX_TIMEOUT - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic {RX_RUN, RX_DROP} rx_state_t;

    tx_state_t                 tx_state;
    logic                      start_d;
    logic                      start_edge;
    logic [C_DATA_FRAME_BIT-1:0] tx_shift;
    logic [IDX_W-1:0]          tx_idx;

    rx_state_t                 rx_state;
    logic [IDX_W-1:0]          rx_idx;
    logic [C_DATA_FRAME_BIT-1:0] rx_buf;
    logic [C_DATA_FRAME_BIT-1:0] rx_assembled;
    logic [TMR_W-1:0]          rx_tmr;

    assign start_edge = i_tx_start_flag & ~start_d;
    assign o_tx_busy  = (tx_state != TX_IDLE);

    // tx_shift keeps the beat currently on the bus in its low slice
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            tx_state      <= TX_IDLE;
            start_d       <= 1'b0;
            tx_shift      <= '0;
            tx_idx        <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            start_d <= i_tx_start_flag;
            case (tx_state)
                TX_IDLE: begin
                    if (start_edge && i_channel_up) begin
                        tx_shift      <= i_tx_data;
                        tx_idx        <= '0;
                        m_axis_tdata  <= i_tx_data[W-1:0];
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        tx_state      <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (!i_channel_up) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        tx_state      <= TX_IDLE;
                    end else if (m_axis_tready) begin
                        if (tx_idx == LAST_IDX) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            tx_state      <= TX_IDLE;
                        end else begin
                            tx_shift     <= tx_shift >> W;
                            m_axis_tdata <= tx_shift[2*W-1:W];
                            m_axis_tlast <= (tx_idx == LAST_IDX - 1'b1);
                            tx_idx       <= tx_idx + 1'b1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_assembled = rx_buf;
        rx_assembled[int'(rx_idx)*W +: W] = s_axis_tdata;
    end

    // rx_tmr is a down-counter reloaded on every beat; zero while idle means the gap limit is reached
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_state       <= RX_RUN;
            rx_idx         <= '0;
            rx_buf         <= '0;
            rx_tmr         <= TMR_LOAD;
            o_rx_data      <= '0;
            o_rx_end_flag  <= 1'b0;
            o_rx_err       <= 1'b0;
            o_rx_frame_cnt <= '0;
        end else begin
            o_rx_end_flag <= 1'b0;
            o_rx_err      <= 1'b0;
            if (!i_channel_up) begin
                rx_state <= RX_RUN;
                rx_idx   <= '0;
                rx_tmr   <= TMR_LOAD;
            end else if (s_axis_tvalid) begin
                rx_tmr <= TMR_LOAD;
                if (rx_state == RX_DROP) begin
                    if (s_axis_tlast) begin
                        rx_state <= RX_RUN;
                    end
                end else if (s_axis_tlast) begin
                    rx_idx <= '0;
                    if (rx_idx == LAST_IDX) begin
                        o_rx_data      <= rx_assembled;
                        o_rx_end_flag  <= 1'b1;
                        o_rx_frame_cnt <= o_rx_frame_cnt + 16'd1;
                    end else begin
                        o_rx_err <= 1'b1;
                    end
                end else if (rx_idx == LAST_IDX) begin
                    o_rx_err <= 1'b1;
                    rx_idx   <= '0;
                    rx_state <= RX_DROP;
                end else begin
                    rx_buf <= rx_assembled;
                    rx_idx <= rx_idx + 1'b1;
                end
            end else if (rx_tmr != '0) begin
                rx_tmr <= rx_tmr - 1'b1;
            end else if (rx_state == RX_RUN && rx_idx != '0) begin
                o_rx_err <= 1'b1;
                rx_idx   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sfp_frame_handler.sv
// Directed bench for sfp_frame_handler: queue-based frame model compared every cycle plus literal spot checks.
module tb_sfp_frame_handler;
    localparam int W  = 64;
    localparam int N  = 2;
    localparam int FB = W * N;
    localparam int TO = 8;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_channel_up = 1'b0;
    logic          i_tx_start_flag = 1'b0;
    logic [FB-1:0] i_tx_data = '0;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [W-1:0]  s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic [FB-1:0] o_rx_data;
    logic          o_rx_end_flag;
    logic          o_tx_busy;
    logic          o_rx_err;
    logic [15:0]   o_rx_frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    sfp_frame_handler #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_NUMBER_OF_FRAME (N),
        .C_DATA_FRAME_BIT  (FB),
        .C_RX_TIMEOUT      (TO)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_channel_up   (i_channel_up),
        .i_tx_start_flag(i_tx_start_flag),
        .i_tx_data      (i_tx_data),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .o_rx_data      (o_rx_data),
        .o_rx_end_flag  (o_rx_end_flag),
        .o_tx_busy      (o_tx_busy),
        .o_rx_err       (o_rx_err),
        .o_rx_frame_cnt (o_rx_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Model: TX is a queue of beats still owed to the link, RX a queue of beats collected so far.
    logic [W-1:0]  tx_q[$];
    logic [W-1:0]  rx_q[$];
    logic          m_start_d = 1'b0;
    logic          m_drop = 1'b0;
    int            m_idle = 0;
    logic [FB-1:0] m_rx_data = '0;
    logic          m_end = 1'b0;
    logic          m_err = 1'b0;
    logic [15:0]   m_cnt = '0;
    logic          preload_req = 1'b0;

    initial forever begin
        logic tx_edge;
        @(posedge i_clk);
        tx_edge = i_tx_start_flag && !m_start_d;
        m_end = 1'b0;
        m_err = 1'b0;
        if (!i_rst) begin
            tx_q.delete();
            rx_q.delete();
            m_start_d = 1'b0;
            m_drop    = 1'b0;
            m_idle    = 0;
            m_rx_data = '0;
            m_cnt     = '0;
        end else begin
            m_start_d = i_tx_start_flag;
            if (tx_q.size() != 0) begin
                if (!i_channel_up) tx_q.delete();
                else if (m_axis_tready) void'(tx_q.pop_front());
            end else if (tx_edge && i_channel_up) begin
                for (int i = 0; i < N; i++) tx_q.push_back(i_tx_data[i*W +: W]);
            end

            if (!i_channel_up) begin
                rx_q.delete();
                m_idle = 0;
                m_drop = 1'b0;
            end else if (s_axis_tvalid) begin
                m_idle = 0;
                if (m_drop) begin
                    if (s_axis_tlast) m_drop = 1'b0;
                end else begin
                    rx_q.push_back(s_axis_tdata);
                    if (s_axis_tlast) begin
                        if (rx_q.size() == N) begin
                            for (int i = 0; i < N; i++) m_rx_data[i*W +: W] = rx_q[i];
                            m_end = 1'b1;
                            m_cnt = m_cnt + 16'd1;
                        end else begin
                            m_err = 1'b1;
                        end
                        rx_q.delete();
                    end else if (rx_q.size() == N) begin
                        m_err  = 1'b1;
                        m_drop = 1'b1;
                        rx_q.delete();
                    end
                end
            end else begin
                m_idle++;
                if (!m_drop && rx_q.size() != 0 && m_idle >= TO) begin
                    m_err = 1'b1;
                    rx_q.delete();
                end
            end
            if (preload_req) m_cnt = 16'hFFFF;
        end
    end

    task automatic chk(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic compare_all();
        chk_b("m_tvalid", m_axis_tvalid, tx_q.size() != 0);
        chk_b("m_busy", o_tx_busy, tx_q.size() != 0);
        if (tx_q.size() != 0) begin
            chk("m_tdata", FB'(m_axis_tdata), FB'(tx_q[0]));
            chk_b("m_tlast", m_axis_tlast, tx_q.size() == 1);
        end else begin
            chk_b("m_tlast_idle", m_axis_tlast, 1'b0);
        end
        chk("m_rx_data", o_rx_data, m_rx_data);
        chk_b("m_rx_end", o_rx_end_flag, m_end);
        chk_b("m_rx_err", o_rx_err, m_err);
        chk("m_rx_cnt", FB'(o_rx_frame_cnt), FB'(m_cnt));
    endtask

    task automatic step();
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic rx_beat(input logic [W-1:0] d, input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        step();
    endtask

    task automatic rx_idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    initial begin
        // reset with random inputs
        i_rst = 1'b0;
        repeat (5) begin
            i_channel_up    = 1'($urandom_range(0, 1));
            i_tx_start_flag = 1'($urandom_range(0, 1));
            i_tx_data       = {$urandom, $urandom, $urandom, $urandom};
            m_axis_tready   = 1'($urandom_range(0, 1));
            s_axis_tdata    = {$urandom, $urandom};
            s_axis_tvalid   = 1'($urandom_range(0, 1));
            s_axis_tlast    = 1'($urandom_range(0, 1));
            step();
        end
        chk_b("rst_tvalid", m_axis_tvalid, 1'b0);
        chk_b("rst_busy", o_tx_busy, 1'b0);
        chk("rst_rx_data", o_rx_data, '0);
        chk("rst_rx_cnt", FB'(o_rx_frame_cnt), '0);
        chk_b("rst_rx_err", o_rx_err, 1'b0);

        i_tx_start_flag = 1'b0;
        i_tx_data       = '0;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        s_axis_tdata    = '0;
        i_channel_up    = 1'b1;
        m_axis_tready   = 1'b1;
        i_rst           = 1'b1;
        repeat (3) step();

        // TX nominal
        i_tx_data       = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
        i_tx_start_flag = 1'b1;
        step();
        chk_b("nom_tvalid0", m_axis_tvalid, 1'b1);
        chk("nom_tdata0", FB'(m_axis_tdata), FB'(64'h2222_2222_2222_2222));
        chk_b("nom_tlast0", m_axis_tlast, 1'b0);
        chk_b("nom_busy0", o_tx_busy, 1'b1);
        step();
        chk("nom_tdata1", FB'(m_axis_tdata), FB'(64'h1111_1111_1111_1111));
        chk_b("nom_tlast1", m_axis_tlast, 1'b1);
        step();
        chk_b("nom_tvalid_end", m_axis_tvalid, 1'b0);
        chk_b("nom_busy_end", o_tx_busy, 1'b0);
        i_tx_start_flag = 1'b0;
        repeat (2) step();

        // TX backpressure, start edge while sending, data change while sending
        m_axis_tready   = 1'b0;
        i_tx_data       = {64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0001};
        i_tx_start_flag = 1'b1;
        step();
        i_tx_data = {$urandom, $urandom, $urandom, $urandom};
        step();
        i_tx_start_flag = 1'b0;
        step();
        i_tx_start_flag = 1'b1;
        step();
        chk("bp_tdata_held", FB'(m_axis_tdata), FB'(64'hAAAA_0000_AAAA_0001));
        chk_b("bp_tvalid_held", m_axis_tvalid, 1'b1);
        m_axis_tready = 1'b1;
        step();
        chk("bp_tdata1", FB'(m_axis_tdata), FB'(64'hBBBB_0000_BBBB_0001));
        step();
        chk_b("bp_no_third_beat", m_axis_tvalid, 1'b0);
        repeat (3) step();
        i_tx_start_flag = 1'b0;
        step();

        // channel drop mid-send
        m_axis_tready   = 1'b0;
        i_tx_start_flag = 1'b1;
        step();
        chk_b("cd_tvalid", m_axis_tvalid, 1'b1);
        i_channel_up = 1'b0;
        step();
        chk_b("cd_tvalid_abort", m_axis_tvalid, 1'b0);
        chk_b("cd_busy_abort", o_tx_busy, 1'b0);
        i_tx_start_flag = 1'b0;
        step();
        // edge with channel down is dropped, not retried
        i_tx_start_flag = 1'b1;
        step();
        i_channel_up = 1'b1;
        repeat (3) step();
        chk_b("cd_no_retry", m_axis_tvalid, 1'b0);
        i_tx_start_flag = 1'b0;
        m_axis_tready   = 1'b1;
        step();

        // RX good frame with a concurrent TX send
        i_tx_data       = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333};
        i_tx_start_flag = 1'b1;
        rx_beat(64'hA, 1'b0);
        i_tx_start_flag = 1'b0;
        rx_beat(64'hB, 1'b1);
        chk("good_data", o_rx_data, {64'hB, 64'hA});
        chk_b("good_end", o_rx_end_flag, 1'b1);
        chk("good_cnt", FB'(o_rx_frame_cnt), FB'(16'd1));
        rx_idle();
        step();
        chk_b("good_end_pulse", o_rx_end_flag, 1'b0);

        // counter wrap: preload 0xFFFF
        #1;
        force dut.o_rx_frame_cnt = 16'hFFFF;
        preload_req = 1'b1;
        step();
        #1;
        release dut.o_rx_frame_cnt;
        preload_req = 1'b0;
        rx_beat(64'hC, 1'b0);
        rx_beat(64'hD, 1'b1);
        chk("wrap_cnt", FB'(o_rx_frame_cnt), '0);
        chk("wrap_data", o_rx_data, {64'hD, 64'hC});
        rx_idle();
        step();

        // short frame
        rx_beat(64'hE, 1'b1);
        chk_b("short_err", o_rx_err, 1'b1);
        chk_b("short_no_end", o_rx_end_flag, 1'b0);
        chk("short_data_kept", o_rx_data, {64'hD, 64'hC});
        rx_idle();
        step();
        chk_b("short_err_pulse", o_rx_err, 1'b0);

        // long frame: one err, tail dropped, next frame accepted
        rx_beat(64'h11, 1'b0);
        rx_beat(64'h12, 1'b0);
        chk_b("long_err", o_rx_err, 1'b1);
        rx_beat(64'h13, 1'b1);
        chk_b("long_no_second_err", o_rx_err, 1'b0);
        rx_beat(64'h21, 1'b0);
        rx_beat(64'h22, 1'b1);
        chk("after_long_data", o_rx_data, {64'h22, 64'h21});
        chk("after_long_cnt", FB'(o_rx_frame_cnt), FB'(16'd1));
        rx_idle();
        step();

        // timeout after TO idle cycles
        rx_beat(64'h5, 1'b0);
        rx_idle();
        for (int i = 1; i <= TO; i++) begin
            step();
            chk_b("timeout_err", o_rx_err, i == TO);
        end
        rx_beat(64'h7, 1'b0);
        rx_beat(64'h8, 1'b1);
        chk("after_to_data", o_rx_data, {64'h8, 64'h7});
        chk("after_to_cnt", FB'(o_rx_frame_cnt), FB'(16'd2));
        rx_idle();
        step();

        // channel drop clears a partial RX frame
        rx_beat(64'h9, 1'b0);
        rx_idle();
        i_channel_up = 1'b0;
        step();
        i_channel_up = 1'b1;
        repeat (TO + 2) step();
        rx_beat(64'hA1, 1'b0);
        rx_beat(64'hA2, 1'b1);
        chk("chdrop_rx_data", o_rx_data, {64'hA2, 64'hA1});
        chk("chdrop_rx_cnt", FB'(o_rx_frame_cnt), FB'(16'd3));
        rx_idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
